fc_score_collector: RTL and testbench

//   Producer side of the 10-class argmax (get_class) interface. Accepts the FC-layer output scores as a serial

---
 rtl/fc_score_collector.sv | 118 +++++++++++
 tb/tb_fc_score_collector.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_score_collector.sv
// Collects ten serial FC-layer scores into parallel registers for the argmax block,
// waits out the argmax pipeline latency, then presents the captured result with valid/ready.
module fc_score_collector #(
  parameter int DW         = 16,
  parameter int ARGMAX_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          score_valid,
  input  logic [DW-1:0] score_data,
  input  logic          score_last,
  output logic          score_ready,
  output logic [DW-1:0] class0,
  output logic [DW-1:0] class1,
  output logic [DW-1:0] class2,
  output logic [DW-1:0] class3,
  output logic [DW-1:0] class4,
  output logic [DW-1:0] class5,
  output logic [DW-1:0] class6,
  output logic [DW-1:0] class7,
  output logic [DW-1:0] class8,
  output logic [DW-1:0] class9,
  input  logic [DW-1:0] class_value,
  input  logic [3:0]    class_index,
  output logic          result_valid,
  input  logic          result_ready,
  output logic [DW-1:0] result_value,
  output logic [3:0]    result_index,
  output logic          frame_err
);

  localparam int WW = $clog2(ARGMAX_LAT + 1);
  localparam logic [WW-1:0] WAIT_END = WW'(ARGMAX_LAT);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    beat_cnt;
  logic [WW-1:0] wait_cnt;
  logic [DW-1:0] cls [10];
  logic          accept;

  // Forcing ready low during reset keeps a beat from being consumed by a collector being cleared.
  assign score_ready = (state == COLLECT) && !rst;
  assign accept      = score_valid && score_ready;

  assign class0 = cls[0];
  assign class1 = cls[1];
  assign class2 = cls[2];
  assign class3 = cls[3];
  assign class4 = cls[4];
  assign class5 = cls[5];
  assign class6 = cls[6];
  assign class7 = cls[7];
  assign class8 = cls[8];
  assign class9 = cls[9];

  // Frame collection, latency wait and result hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= COLLECT;
      beat_cnt     <= 4'd0;
      wait_cnt     <= '0;
      result_valid <= 1'b0;
      result_value <= '0;
      result_index <= 4'd0;
      frame_err    <= 1'b0;
      for (int i = 0; i < 10; i++) begin
        cls[i] <= '0;
      end
    end else begin
      frame_err <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            cls[beat_cnt] <= score_data;
            if (beat_cnt == 4'd9) begin
              // A missing last marker is flagged, but ten beats are still a usable frame.
              beat_cnt  <= 4'd0;
              wait_cnt  <= '0;
              frame_err <= !score_last;
              state     <= WAIT;
            end else if (score_last) begin
              beat_cnt  <= 4'd0;
              frame_err <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_END) begin
            result_value <= class_value;
            result_index <= class_index;
            result_valid <= 1'b1;
            state        <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= COLLECT;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_score_collector.sv
// Directed bench for fc_score_collector with a 4-stage behavioural argmax model on the class ports.
module tb_fc_score_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        score_valid = 1'b0;
  logic [15:0] score_data = 16'd0;
  logic        score_last = 1'b0;
  logic        score_ready;
  logic [15:0] class0, class1, class2, class3, class4, class5, class6, class7, class8, class9;
  logic [15:0] class_value;
  logic [3:0]  class_index;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [15:0] result_value;
  logic [3:0]  result_index;
  logic        frame_err;

  int total = 0;
  int bad   = 0;

  logic [159:0] cls_all;
  assign cls_all = {class9, class8, class7, class6, class5, class4, class3, class2, class1, class0};

  fc_score_collector #(.DW(16), .ARGMAX_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .score_valid(score_valid), .score_data(score_data), .score_last(score_last),
    .score_ready(score_ready),
    .class0(class0), .class1(class1), .class2(class2), .class3(class3), .class4(class4),
    .class5(class5), .class6(class6), .class7(class7), .class8(class8), .class9(class9),
    .class_value(class_value), .class_index(class_index),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_value(result_value), .result_index(result_index),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Downstream argmax model: unsigned compare, lowest index wins ties, 4 register stages.
  function automatic logic [19:0] argmax(input logic [159:0] v);
    logic [15:0] best;
    logic [3:0]  idx;
    best = v[15:0];
    idx  = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (v[i*16 +: 16] > best) begin
        best = v[i*16 +: 16];
        idx  = 4'(i);
      end
    end
    return {idx, best};
  endfunction

  logic [19:0] pipe [4];
  always @(posedge clk) begin
    pipe[0] <= argmax(cls_all);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
    pipe[3] <= pipe[2];
  end
  assign class_value = pipe[3][15:0];
  assign class_index = pipe[3][19:16];

  // Called at a negedge; returns at the negedge after the accepting edge with frame_err sampled there.
  task automatic send_beat(input logic [15:0] d, input logic l, output logic fe);
    int n = 0;
    score_valid = 1'b1;
    score_data  = d;
    score_last  = l;
    #1;
    while (!score_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL beat_timeout: score_ready never rose in %0d cycles", n);
    end
    @(negedge clk);
    fe = frame_err;
    score_valid = 1'b0;
    score_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [159:0] s, input logic last9, output logic fe9);
    logic fe;
    fe9 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_beat(s[i*16 +: 16], (i == 9) ? last9 : 1'b0, fe);
      if (i == 9) fe9 = fe;
    end
  endtask

  // Starts at the negedge after beat 9 is accepted.
  task automatic wait_result(input logic [159:0] exp_cls, input logic [15:0] ev, input logic [3:0] ei);
    int   n = 0;
    logic stable = 1'b1;
    while (!result_valid && n < 20) begin
      if (cls_all !== exp_cls || score_ready !== 1'b0) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 5) begin bad++; $display("FAIL latency: got %0d cycles, want 5", n); end
    total++;
    if (stable !== 1'b1) begin bad++; $display("FAIL wait_stable: class regs or score_ready changed during wait"); end
    total++;
    if (result_value !== ev) begin bad++; $display("FAIL result_value: got %h want %h", result_value, ev); end
    total++;
    if (result_index !== ei) begin bad++; $display("FAIL result_index: got %0d want %0d", result_index, ei); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (score_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", score_ready); end
    total++;
    if (result_valid !== 1'b0 || frame_err !== 1'b0) begin
      bad++; $display("FAIL rst_flags: valid=%b err=%b want 0 0", result_valid, frame_err);
    end
    total++;
    if (cls_all !== 160'd0 || result_value !== 16'd0 || result_index !== 4'd0) begin
      bad++; $display("FAIL rst_regs: class=%h value=%h index=%0d want zeros", cls_all, result_value, result_index);
    end
    rst = 1'b0;
    #1;
    total++;
    if (score_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", score_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [159:0] s;
    logic fe;
    for (int i = 0; i < 10; i++) s[i*16 +: 16] = 16'(10 * (i + 1));
    result_ready = 1'b1;
    send_frame(s, 1'b1, fe);
    total++;
    if (fe !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", fe); end
    wait_result(s, 16'd100, 4'd9);
    @(negedge clk);
    total++;
    if (result_valid !== 1'b0 || score_ready !== 1'b1) begin
      bad++; $display("FAIL basic_release: valid=%b ready=%b want 0 1", result_valid, score_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [159:0] s;
    logic fe;
    for (int i = 0; i < 10; i++) s[i*16 +: 16] = 16'd5;
    s[3*16 +: 16] = 16'h7FFF;
    send_frame(s, 1'b1, fe);
    wait_result(s, 16'h7FFF, 4'd3);
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic fe;
    logic seen;
    logic [159:0] s;
    for (int i = 0; i < 4; i++) send_beat(16'(i + 40), 1'b0, fe);
    send_beat(16'd44, 1'b1, fe);
    total++;
    if (fe !== 1'b1) begin bad++; $display("FAIL abort_err: got %b want 1", fe); end
    total++;
    if (class4 !== 16'd44 || class0 !== 16'd40) begin
      bad++; $display("FAIL abort_keep: class0=%0d class4=%0d want 40 44", class0, class4);
    end
    @(negedge clk);
    total++;
    if (frame_err !== 1'b0) begin bad++; $display("FAIL abort_pulse: got %b want 0", frame_err); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (result_valid !== 1'b0 || score_ready !== 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL abort_noresult: result appeared or ready dropped"); end
    s = {16'd3, 16'd5, 16'd6, 16'd2, 16'd9, 16'd5, 16'd1, 16'd4, 16'd1, 16'd3};
    send_frame(s, 1'b1, fe);
    wait_result(s, 16'd9, 4'd5);
    @(negedge clk);
  endtask

  task automatic test_hold();
    logic [159:0] s;
    logic fe;
    logic ok;
    s = {16'd0, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd1, 16'd8, 16'd8, 16'd2};
    result_ready = 1'b0;
    send_frame(s, 1'b1, fe);
    wait_result(s, 16'd8, 4'd1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (result_valid !== 1'b1 || score_ready !== 1'b0 || result_value !== 16'd8 || result_index !== 4'd1) ok = 1'b0;
    end
    total++;
    if (ok !== 1'b1) begin
      bad++; $display("FAIL hold_stable: valid=%b ready=%b value=%0d index=%0d", result_valid, score_ready, result_value, result_index);
    end
    result_ready = 1'b1;
    @(negedge clk);
    total++;
    if (result_valid !== 1'b0 || score_ready !== 1'b1) begin
      bad++; $display("FAIL hold_release: valid=%b ready=%b want 0 1", result_valid, score_ready);
    end
  endtask

  task automatic test_nolast();
    logic [159:0] s;
    logic fe;
    for (int i = 0; i < 10; i++) s[i*16 +: 16] = 16'h8000 + 16'(i);
    s[15:0] = 16'hFFFF;
    send_frame(s, 1'b0, fe);
    total++;
    if (fe !== 1'b1) begin bad++; $display("FAIL nolast_err: got %b want 1", fe); end
    wait_result(s, 16'hFFFF, 4'd0);
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    logic [159:0] s;
    logic fe;
    logic seen;
    for (int i = 0; i < 10; i++) s[i*16 +: 16] = 16'(i + 1);
    send_frame(s, 1'b1, fe);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (cls_all !== 160'd0 || result_valid !== 1'b0 || result_value !== 16'd0 || result_index !== 4'd0
        || frame_err !== 1'b0 || score_ready !== 1'b0) begin
      bad++; $display("FAIL wait_rst: class=%h valid=%b value=%h ready=%b want zeros", cls_all, result_valid, result_value, score_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (result_valid !== 1'b0 || score_ready !== 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL wait_rst_after: result appeared or ready low after reset"); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_hold();
    test_nolast();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
